// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port word SRAM between the instruction-fetch and data ports.
// Data wins by default; a fetch that keeps losing is let through once the starvation count saturates.
module mem_port_arbiter #(
    parameter  int unsigned MEM_WORDS    = 1024,
    parameter  int unsigned STARVE_LIMIT = 4,
    parameter  logic [31:0] OOR_INSTR    = 32'hdeadbeef,
    localparam int unsigned AW           = $clog2(MEM_WORDS)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_req,
    input  logic [31:0]   i_addr,
    output logic          i_gnt,
    output logic          i_rvalid,
    output logic [31:0]   i_rdata,
    input  logic          d_req,
    input  logic [31:0]   d_addr,
    input  logic [31:0]   d_wdata,
    input  logic [3:0]    d_wen,
    output logic          d_gnt,
    output logic          d_rvalid,
    output logic [31:0]   d_rdata,
    output logic          d_err,
    output logic          mem_en,
    output logic [AW-1:0] mem_addr,
    output logic [3:0]    mem_wen,
    output logic [31:0]   mem_wdata,
    input  logic [31:0]   mem_rdata
);

    localparam logic [31:0] ADDR_LIMIT = 32'(4 * MEM_WORDS);
    localparam logic [3:0]  STARVE_MAX = 4'(STARVE_LIMIT);

    typedef enum logic {
        ST_FLUSH,
        ST_RUN
    } state_t;

    typedef enum logic [1:0] {
        RSEL_NONE,
        RSEL_I,
        RSEL_D
    } rsel_t;

    state_t      r_state;
    state_t      w_state_nxt;
    rsel_t       r_rsel;
    rsel_t       w_rsel_nxt;
    logic        r_roor;
    logic        w_roor_nxt;
    logic [3:0]  r_starve_cnt;
    logic [31:0] r_i_rdata;
    logic [31:0] r_d_rdata;
    logic [31:0] w_i_rdata;
    logic [31:0] w_d_rdata;
    logic        w_i_oor;
    logic        w_d_oor;
    logic        w_starved;
    logic [AW-1:0] w_i_idx;
    logic [AW-1:0] w_d_idx;

    assign w_i_oor   = (i_addr >= ADDR_LIMIT);
    assign w_d_oor   = (d_addr >= ADDR_LIMIT);
    assign w_i_idx   = i_addr[AW+1:2];
    assign w_d_idx   = d_addr[AW+1:2];
    assign w_starved = (r_starve_cnt == STARVE_MAX);

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_FLUSH;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state, arbitration and SRAM drive
    always_comb begin
        w_state_nxt = r_state;
        i_gnt       = 1'b0;
        d_gnt       = 1'b0;
        d_err       = 1'b0;
        mem_en      = 1'b0;
        mem_addr    = w_d_idx;
        mem_wen     = 4'b0000;
        mem_wdata   = d_wdata;
        w_rsel_nxt  = RSEL_NONE;
        w_roor_nxt  = 1'b0;

        case (r_state)
            ST_FLUSH: w_state_nxt = ST_RUN;
            ST_RUN: begin
                w_state_nxt = ST_RUN;
                // Grants are suppressed while reset is being asserted mid-run
                if (rst_n) begin
                    if (d_req && !(i_req && w_starved)) begin
                        d_gnt = 1'b1;
                    end else if (i_req) begin
                        i_gnt = 1'b1;
                    end
                end
            end
            default: w_state_nxt = ST_FLUSH;
        endcase

        if (i_gnt) begin
            mem_en     = !w_i_oor;
            mem_addr   = w_i_idx;
            w_rsel_nxt = RSEL_I;
            w_roor_nxt = w_i_oor;
        end

        if (d_gnt) begin
            mem_en  = !w_d_oor;
            mem_wen = w_d_oor ? 4'b0000 : d_wen;
            d_err   = w_d_oor;
            if (d_wen == 4'b0000) begin
                w_rsel_nxt = RSEL_D;
                w_roor_nxt = w_d_oor;
            end
        end
    end

    // Read-return stage, starvation counter and per-port data hold
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rsel       <= RSEL_NONE;
            r_roor       <= 1'b0;
            r_starve_cnt <= 4'd0;
            r_i_rdata    <= 32'd0;
            r_d_rdata    <= 32'd0;
        end else begin
            r_rsel <= w_rsel_nxt;
            r_roor <= w_roor_nxt;
            if (!i_req || i_gnt) begin
                r_starve_cnt <= 4'd0;
            end else if (d_gnt && !w_starved) begin
                r_starve_cnt <= r_starve_cnt + 4'd1;
            end
            if (r_rsel == RSEL_I) begin
                r_i_rdata <= w_i_rdata;
            end
            if (r_rsel == RSEL_D) begin
                r_d_rdata <= w_d_rdata;
            end
        end
    end

    assign w_i_rdata = (r_rsel == RSEL_I) ? (r_roor ? OOR_INSTR : mem_rdata) : r_i_rdata;
    assign w_d_rdata = (r_rsel == RSEL_D) ? (r_roor ? 32'd0 : mem_rdata) : r_d_rdata;

    // A reset arriving during the return cycle discards the pending response
    assign i_rvalid = rst_n && (r_rsel == RSEL_I);
    assign d_rvalid = rst_n && (r_rsel == RSEL_D);
    assign i_rdata  = rst_n ? w_i_rdata : 32'd0;
    assign d_rdata  = rst_n ? w_d_rdata : 32'd0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: behavioural SRAM, per-scenario tasks, and a queue
// scoreboard that matches read data against expectations pushed when each read is driven.
module tb_mem_port_arbiter;

    localparam int unsigned AW = 10;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          i_req;
    logic [31:0]   i_addr;
    logic          i_gnt;
    logic          i_rvalid;
    logic [31:0]   i_rdata;
    logic          d_req;
    logic [31:0]   d_addr;
    logic [31:0]   d_wdata;
    logic [3:0]    d_wen;
    logic          d_gnt;
    logic          d_rvalid;
    logic [31:0]   d_rdata;
    logic          d_err;
    logic          mem_en;
    logic [AW-1:0] mem_addr;
    logic [3:0]    mem_wen;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem_rdata;

    logic [31:0] sram [0:1023];
    logic        sram_loaded = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] iq[$];
    logic [31:0] dq[$];

    mem_port_arbiter dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_req    (i_req),
        .i_addr   (i_addr),
        .i_gnt    (i_gnt),
        .i_rvalid (i_rvalid),
        .i_rdata  (i_rdata),
        .d_req    (d_req),
        .d_addr   (d_addr),
        .d_wdata  (d_wdata),
        .d_wen    (d_wen),
        .d_gnt    (d_gnt),
        .d_rvalid (d_rvalid),
        .d_rdata  (d_rdata),
        .d_err    (d_err),
        .mem_en   (mem_en),
        .mem_addr (mem_addr),
        .mem_wen  (mem_wen),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Synchronous SRAM; contents seeded on the first edge, word j = A500_0000 | j except word 2
    always @(posedge clk) begin
        if (!sram_loaded) begin
            for (int j = 0; j < 1024; j++) begin
                sram[j] = (j == 2) ? 32'h00300093 : (32'hA5000000 | 32'(j));
            end
            sram_loaded = 1'b1;
        end
        if (mem_en) begin
            if (mem_wen == 4'b0000) begin
                mem_rdata <= sram[mem_addr];
            end else begin
                for (int b = 0; b < 4; b++) begin
                    if (mem_wen[b]) sram[mem_addr][8*b +: 8] = mem_wdata[8*b +: 8];
                end
            end
        end
    end

    // Scoreboard: every rvalid must match the oldest outstanding expectation on that port
    always @(negedge clk) begin
        logic [31:0] exp_v;
        if (i_rvalid) begin
            n_tests++;
            if (iq.size() == 0) begin
                n_fail++;
                $display("FAIL sb_i_unexpected: i_rvalid with no read outstanding, rdata=%h", i_rdata);
            end else begin
                exp_v = iq.pop_front();
                if (i_rdata !== exp_v) begin
                    n_fail++;
                    $display("FAIL sb_i_rdata: got %h want %h", i_rdata, exp_v);
                end
            end
        end
        if (d_rvalid) begin
            n_tests++;
            if (dq.size() == 0) begin
                n_fail++;
                $display("FAIL sb_d_unexpected: d_rvalid with no read outstanding, rdata=%h", d_rdata);
            end else begin
                exp_v = dq.pop_front();
                if (d_rdata !== exp_v) begin
                    n_fail++;
                    $display("FAIL sb_d_rdata: got %h want %h", d_rdata, exp_v);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; i_req = 1'b1; i_addr = 32'h8;
        d_req = 1'b0; d_addr = 32'h0; d_wdata = 32'h0; d_wen = 4'h0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        n_tests++;
        if ({i_gnt, d_gnt, i_rvalid, d_rvalid, d_err, mem_en, mem_wen, i_rdata, d_rdata} !== 74'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got gnt=%b%b rv=%b%b err=%b en=%b wen=%h ird=%h drd=%h want all 0",
                     i_gnt, d_gnt, i_rvalid, d_rvalid, d_err, mem_en, mem_wen, i_rdata, d_rdata);
        end
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        n_tests++;
        if ({i_gnt, d_gnt, mem_en} !== 3'b000) begin
            n_fail++;
            $display("FAIL flush_no_gnt: got i_gnt=%b d_gnt=%b mem_en=%b want 000", i_gnt, d_gnt, mem_en);
        end
        tick();
        iq.push_back(32'h00300093);
        @(negedge clk);
        n_tests++;
        if ({i_gnt, d_gnt, mem_en, mem_wen, mem_addr} !== {3'b101, 4'h0, 10'd2}) begin
            n_fail++;
            $display("FAIL first_fetch_gnt: got gnt=%b%b en=%b wen=%h addr=%0d want gnt=10 en=1 wen=0 addr=2",
                     i_gnt, d_gnt, mem_en, mem_wen, mem_addr);
        end
        tick();
        i_req = 1'b0;
        @(negedge clk);
        n_tests++;
        if ({i_rvalid, i_gnt} !== 2'b10) begin
            n_fail++;
            $display("FAIL first_fetch_rvalid: got rvalid=%b gnt=%b want 1 0", i_rvalid, i_gnt);
        end
    endtask

    task automatic test_write_read();
        tick();
        d_req = 1'b1; d_addr = 32'h100; d_wen = 4'hF; d_wdata = 32'd300;
        @(negedge clk);
        n_tests++;
        if ({d_gnt, i_gnt, d_err, mem_en, mem_wen, mem_addr, mem_wdata} !== {4'b1001, 4'hF, 10'd64, 32'd300}) begin
            n_fail++;
            $display("FAIL write_drive: got gnt=%b%b err=%b en=%b wen=%h addr=%0d wd=%0d want d_gnt en wen=f addr=64 wd=300",
                     d_gnt, i_gnt, d_err, mem_en, mem_wen, mem_addr, mem_wdata);
        end
        tick();
        d_wen = 4'h0;
        dq.push_back(32'd300);
        @(negedge clk);
        n_tests++;
        if ({d_rvalid, d_gnt, mem_en, mem_wen} !== {3'b011, 4'h0}) begin
            n_fail++;
            $display("FAIL read_gnt_after_write: got rvalid=%b gnt=%b en=%b wen=%h want 0 1 1 0",
                     d_rvalid, d_gnt, mem_en, mem_wen);
        end
        tick();
        d_req = 1'b0;
        @(negedge clk);
        n_tests++;
        if ({d_rvalid, d_gnt, i_rdata} !== {2'b10, 32'h00300093}) begin
            n_fail++;
            $display("FAIL read_rvalid_hold: got rvalid=%b gnt=%b i_rdata=%h want 1 0 00300093",
                     d_rvalid, d_gnt, i_rdata);
        end
        tick();
        @(negedge clk);
        n_tests++;
        if ({d_rvalid, d_rdata} !== {1'b0, 32'd300}) begin
            n_fail++;
            $display("FAIL d_rdata_hold: got rvalid=%b rdata=%0d want 0 300", d_rvalid, d_rdata);
        end
    endtask

    task automatic test_contention();
        logic exp_i;
        logic prev_i = 1'b0;
        tick();
        i_req = 1'b1; i_addr = 32'h8; d_req = 1'b1; d_addr = 32'h100; d_wen = 4'h0;
        for (int k = 0; k < 10; k++) begin
            exp_i = (k % 5 == 4);
            if (exp_i) iq.push_back(32'h00300093);
            else       dq.push_back(32'd300);
            @(negedge clk);
            n_tests++;
            if ({i_gnt, d_gnt} !== {exp_i, !exp_i}) begin
                n_fail++;
                $display("FAIL contend_gnt[%0d]: got i_gnt=%b d_gnt=%b want %b %b", k, i_gnt, d_gnt, exp_i, !exp_i);
            end
            if (k > 0) begin
                n_tests++;
                if ({i_rvalid, d_rvalid} !== {prev_i, !prev_i}) begin
                    n_fail++;
                    $display("FAIL contend_rvalid[%0d]: got %b%b want %b%b", k, i_rvalid, d_rvalid, prev_i, !prev_i);
                end
            end
            prev_i = exp_i;
            tick();
        end
        i_req = 1'b0; d_req = 1'b0;
        @(negedge clk);
        n_tests++;
        if ({i_rvalid, d_rvalid, i_gnt, d_gnt} !== {prev_i, !prev_i, 2'b00}) begin
            n_fail++;
            $display("FAIL contend_tail: got rv=%b%b gnt=%b%b want rv=%b%b gnt=00",
                     i_rvalid, d_rvalid, i_gnt, d_gnt, prev_i, !prev_i);
        end
    endtask

    task automatic test_back_to_back();
        logic fetch;
        logic prev_fetch = 1'b0;
        logic [AW-1:0] word;
        tick();
        for (int k = 0; k < 8; k++) begin
            fetch  = (k % 2 == 0);
            word   = fetch ? AW'(8 + k) : AW'(24 + k);
            i_req  = fetch;
            d_req  = !fetch;
            i_addr = 32'(word) << 2;
            d_addr = 32'(word) << 2;
            d_wen  = 4'h0;
            if (fetch) iq.push_back(32'hA5000000 | 32'(word));
            else       dq.push_back(32'hA5000000 | 32'(word));
            @(negedge clk);
            n_tests++;
            if ({i_gnt, d_gnt, mem_en, mem_addr} !== {fetch, !fetch, 1'b1, word}) begin
                n_fail++;
                $display("FAIL b2b_gnt[%0d]: got gnt=%b%b en=%b addr=%0d want gnt=%b%b en=1 addr=%0d",
                         k, i_gnt, d_gnt, mem_en, mem_addr, fetch, !fetch, word);
            end
            if (k > 0) begin
                n_tests++;
                if ({i_rvalid, d_rvalid} !== {prev_fetch, !prev_fetch}) begin
                    n_fail++;
                    $display("FAIL b2b_rvalid[%0d]: got %b%b want %b%b", k, i_rvalid, d_rvalid, prev_fetch, !prev_fetch);
                end
            end
            prev_fetch = fetch;
            tick();
        end
        i_req = 1'b0; d_req = 1'b0;
        @(negedge clk);
        n_tests++;
        if ({i_rvalid, d_rvalid} !== {prev_fetch, !prev_fetch}) begin
            n_fail++;
            $display("FAIL b2b_tail: got %b%b want %b%b", i_rvalid, d_rvalid, prev_fetch, !prev_fetch);
        end
    endtask

    task automatic test_out_of_range();
        tick();
        i_req = 1'b1; i_addr = 32'h1000;
        iq.push_back(32'hdeadbeef);
        @(negedge clk);
        n_tests++;
        if ({i_gnt, mem_en, d_err} !== 3'b100) begin
            n_fail++;
            $display("FAIL oor_fetch: got gnt=%b en=%b err=%b want 1 0 0", i_gnt, mem_en, d_err);
        end
        tick();
        i_addr = 32'hFFC;
        iq.push_back(32'hA50003FF);
        @(negedge clk);
        n_tests++;
        if ({i_gnt, mem_en, mem_addr} !== {2'b11, 10'd1023}) begin
            n_fail++;
            $display("FAIL edge_fetch: got gnt=%b en=%b addr=%0d want 1 1 1023", i_gnt, mem_en, mem_addr);
        end
        tick();
        i_req = 1'b0;
        d_req = 1'b1; d_addr = 32'h2000; d_wen = 4'hF; d_wdata = 32'h12345678;
        @(negedge clk);
        n_tests++;
        if ({d_gnt, d_err, mem_en, mem_wen} !== {3'b110, 4'h0}) begin
            n_fail++;
            $display("FAIL oor_write: got gnt=%b err=%b en=%b wen=%h want 1 1 0 0", d_gnt, d_err, mem_en, mem_wen);
        end
        tick();
        d_addr = 32'h1000; d_wen = 4'h0;
        dq.push_back(32'd0);
        @(negedge clk);
        n_tests++;
        if ({d_gnt, d_err, mem_en} !== 3'b110) begin
            n_fail++;
            $display("FAIL oor_read: got gnt=%b err=%b en=%b want 1 1 0", d_gnt, d_err, mem_en);
        end
        tick();
        d_addr = 32'h0;
        dq.push_back(32'hA5000000);
        @(negedge clk);
        n_tests++;
        if ({d_gnt, d_err, mem_en, mem_addr} !== {3'b101, 10'd0}) begin
            n_fail++;
            $display("FAIL oor_readback_gnt: got gnt=%b err=%b en=%b addr=%0d want 1 0 1 0",
                     d_gnt, d_err, mem_en, mem_addr);
        end
        tick();
        d_req = 1'b0;
        @(negedge clk);
        n_tests++;
        if ({d_rvalid, d_err} !== 2'b10) begin
            n_fail++;
            $display("FAIL oor_tail: got rvalid=%b err=%b want 1 0", d_rvalid, d_err);
        end
    endtask

    task automatic test_reset_mid_read();
        tick();
        d_req = 1'b1; d_addr = 32'h100; d_wen = 4'h0;
        dq.push_back(32'd300);
        @(negedge clk);
        n_tests++;
        if (d_gnt !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_read_gnt: got %b want 1", d_gnt);
        end
        tick();
        rst_n = 1'b0; d_req = 1'b0; i_req = 1'b1; i_addr = 32'h8;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            n_tests++;
            if ({i_gnt, d_gnt, i_rvalid, d_rvalid, d_err, mem_en, mem_wen, i_rdata, d_rdata} !== 74'd0) begin
                n_fail++;
                $display("FAIL mid_reset_outputs[%0d]: got gnt=%b%b rv=%b%b err=%b en=%b wen=%h ird=%h drd=%h want all 0",
                         c, i_gnt, d_gnt, i_rvalid, d_rvalid, d_err, mem_en, mem_wen, i_rdata, d_rdata);
            end
            tick();
        end
        dq.delete();
        rst_n = 1'b1;
        @(negedge clk);
        n_tests++;
        if ({i_gnt, d_gnt, i_rvalid, d_rvalid} !== 4'b0000) begin
            n_fail++;
            $display("FAIL mid_flush: got gnt=%b%b rv=%b%b want 0000", i_gnt, d_gnt, i_rvalid, d_rvalid);
        end
        tick();
        iq.push_back(32'h00300093);
        @(negedge clk);
        n_tests++;
        if (i_gnt !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_refetch_gnt: got %b want 1", i_gnt);
        end
        tick();
        i_req = 1'b0;
        @(negedge clk);
        n_tests++;
        if (i_rvalid !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_refetch_rvalid: got %b want 1", i_rvalid);
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_contention();
        test_back_to_back();
        test_out_of_range();
        test_reset_mid_read();
        tick();
        @(negedge clk);
        n_tests++;
        if ((iq.size() != 0) || (dq.size() != 0)) begin
            n_fail++;
            $display("FAIL sb_drain: got %0d fetch and %0d data reads outstanding want 0 0", iq.size(), dq.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
